// File: rtl/vm80a_intc_if.sv
// vm80a_intc_if -- Wishbone register-bus bundle for the vm80a_intc interrupt
// controller.
//   wb_adr_i [1:0] register select      wb_dat_i [7:0] write data
//   wb_dat_o [7:0] read data            wb_cyc_i/wb_stb_i/wb_we_i  cycle/strobe/write
//   wb_ack_o       single-clock acknowledge
// master: bus initiator (CPU bridge / testbench); slave: the controller.
interface vm80a_intc_if;
  logic [1:0] wb_adr_i;
  logic [7:0] wb_dat_i;
  logic [7:0] wb_dat_o;
  logic       wb_cyc_i;
  logic       wb_stb_i;
  logic       wb_we_i;
  logic       wb_ack_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_cyc_i, wb_stb_i, wb_we_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_cyc_i, wb_stb_i, wb_we_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/vm80a_intc.sv
// vm80a_intc -- 8-input priority interrupt controller for an 8080-style CPU.
// Delivers RST opcodes (8'hC7 | n<<3) during the INTA read cycle; bit0 of
// irq_i is the highest priority. Nested service via the ISR.
// Ports:
//   wb_clk_i, wb_rst_n  clock, asynchronous active-low reset
//   wb                  Wishbone slave (adr0 IRR, adr1 IMR, adr2 ISR/EOI,
//                       adr3 last delivered vector)
//   irq_i[7:0]          asynchronous interrupt sources
//   cpu_sync, cpu_dout, cpu_dbin  CPU status strobe, data out, read strobe
//   cpu_int             interrupt request to the CPU
//   inta_o, vec_o       vector owns the CPU read mux / RST opcode
// Configuration macro: VM80A_INTC_EDGE_EN -- when defined, IRR latches rising
// edges; otherwise IRR mirrors the synchronized level.
module vm80a_intc #(
  parameter logic [7:0] MASK_INIT = 8'hFF,
  parameter logic [7:0] SPUR_VEC  = 8'hFF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n,
  vm80a_intc_if.slave wb,
  input  logic [7:0]  irq_i,
  input  logic        cpu_sync,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_dbin,
  output logic        cpu_int,
  output logic        inta_o,
  output logic [7:0]  vec_o
);

  typedef enum logic [1:0] {IDLE, VEC, READ} state_t;

  state_t     state_q, state_d;
  logic [7:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [7:0] irr_q, irr_d, imr_q, imr_d, isr_q, isr_d;
  logic [7:0] vec_q, vec_d, last_q, last_d, dat_q, dat_d;
  logic [2:0] num_q, num_d;
  logic       spur_q, spur_d, ack_q, ack_d;
  logic       int_q, int_d, inta_q, inta_d;
`ifdef VM80A_INTC_EDGE_EN
  logic [7:0] hist_q, hist_d;
`endif

  logic       wr, commit;
  logic [3:0] win;
  logic       unused_dout;

  assign unused_dout = ^cpu_dout[7:1];

  // Returns {valid, index}: lowest pending bit strictly above (in priority)
  // the highest-priority in-service bit.
  function automatic logic [3:0] pick(input logic [7:0] pend, input logic [7:0] isr);
    logic [3:0] r;
    logic       blocked;
    r       = 4'd0;
    blocked = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (isr[i]) blocked = 1'b1;
      if (!blocked && !r[3] && pend[i]) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    sync1_d = irq_i;
    sync2_d = sync1_q;
    imr_d   = imr_q;
    isr_d   = isr_q;
    vec_d   = vec_q;
    last_d  = last_q;
    num_d   = num_q;
    spur_d  = spur_q;
    dat_d   = dat_q;
    commit  = 1'b0;
    win     = pick(irr_q & ~imr_q, isr_q);

    // One wait state; the ~ack_q term stops a held strobe re-acking at once.
    ack_d = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q;
    wr    = ack_d & wb.wb_we_i;
    if (ack_d && !wb.wb_we_i) begin
      case (wb.wb_adr_i)
        2'd0:    dat_d = irr_q;
        2'd1:    dat_d = imr_q;
        2'd2:    dat_d = isr_q;
        default: dat_d = last_q;
      endcase
    end

    case (state_q)
      IDLE: if (cpu_sync && cpu_dout[0]) begin
        state_d = VEC;
        num_d   = win[2:0];
        spur_d  = !win[3];
        vec_d   = win[3] ? (8'hC7 | {2'b00, win[2:0], 3'b000}) : SPUR_VEC;
      end
      VEC: begin
        if (cpu_dbin) state_d = READ;
        else if (cpu_sync && !cpu_dout[0]) state_d = IDLE;
      end
      READ: if (!cpu_dbin) begin
        state_d = IDLE;
        last_d  = vec_q;
        commit  = !spur_q;
      end
      default: state_d = IDLE;
    endcase

    if (wr && wb.wb_adr_i == 2'd1) imr_d = wb.wb_dat_i;
    // EOI clears the lowest set bit before the commit bit is applied.
    if (wr && wb.wb_adr_i == 2'd2) isr_d = isr_q & (isr_q - 8'd1);
    if (commit) isr_d = isr_d | (8'd1 << num_q);

`ifdef VM80A_INTC_EDGE_EN
    hist_d = sync2_q;
    irr_d  = irr_q;
    if (wr && wb.wb_adr_i == 2'd0) irr_d = irr_d & ~wb.wb_dat_i;
    if (commit) irr_d = irr_d & ~(8'd1 << num_q);
    irr_d = irr_d | (sync2_q & ~hist_q);
`else
    irr_d = sync2_q;
`endif

    // Suppressed on the clocks that leave or enter IDLE so a just-committed
    // request cannot flash cpu_int before ISR/IRR settle.
    int_d  = (state_q == IDLE) && (state_d == IDLE) && win[3];
    inta_d = (state_d != IDLE);
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q <= IDLE;
      sync1_q <= 8'h00;
      sync2_q <= 8'h00;
      irr_q   <= 8'h00;
      imr_q   <= MASK_INIT;
      isr_q   <= 8'h00;
      vec_q   <= 8'hFF;
      last_q  <= 8'hFF;
      dat_q   <= 8'h00;
      num_q   <= 3'd0;
      spur_q  <= 1'b0;
      ack_q   <= 1'b0;
      int_q   <= 1'b0;
      inta_q  <= 1'b0;
`ifdef VM80A_INTC_EDGE_EN
      hist_q  <= 8'h00;
`endif
    end else begin
      state_q <= state_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      irr_q   <= irr_d;
      imr_q   <= imr_d;
      isr_q   <= isr_d;
      vec_q   <= vec_d;
      last_q  <= last_d;
      dat_q   <= dat_d;
      num_q   <= num_d;
      spur_q  <= spur_d;
      ack_q   <= ack_d;
      int_q   <= int_d;
      inta_q  <= inta_d;
`ifdef VM80A_INTC_EDGE_EN
      hist_q  <= hist_d;
`endif
    end
  end

  assign wb.wb_ack_o = ack_q;
  assign wb.wb_dat_o = dat_q;
  assign cpu_int     = int_q;
  assign inta_o      = inta_q;
  assign vec_o       = vec_q;

endmodule
